// File: rtl/risc_core_param.sv
// Parametrised accumulator CPU core (HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP) with a
// req/ready memory port, carry flag, resume-from-halt and retired counter.
module risc_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halt,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [DATA_W-1:0]   ir_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   acc_r;
    logic                carry_r;
    logic [CNT_W-1:0]    retired_r;

    logic [2:0]          opcode_s;
    logic [ADDR_W-1:0]   opaddr_s;
    logic                mem_op_s;
    logic                req_s;
    logic                we_s;
    logic                done_s;
    logic [DATA_W:0]     sum_s;

    function automatic logic [DATA_W:0] add_with_carry(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign opcode_s = ir_r[DATA_W-1:DATA_W-3];
    assign opaddr_s = ir_r[ADDR_W-1:0];
    assign sum_s    = add_with_carry(acc_r, mem_rdata);

    // Any instruction bits between opcode and address are deliberately ignored.
    generate
        if (DATA_W - 3 > ADDR_W) begin : g_gap
            logic unused_gap_s;
            assign unused_gap_s = ^ir_r[DATA_W-4:ADDR_W];
        end
    endgenerate

    // Bus request decode; reset low forces the request off immediately.
    always_comb begin
        mem_op_s = 1'b0;
        req_s    = 1'b0;
        we_s     = 1'b0;
        case (opcode_s)
            OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO: mem_op_s = 1'b1;
            default:                                mem_op_s = 1'b0;
        endcase
        if (!rst_n) begin
            req_s = 1'b0;
        end else if (state_r == ST_FETCH) begin
            req_s = 1'b1;
        end else if (state_r == ST_EXEC) begin
            req_s = mem_op_s;
            we_s  = mem_op_s && (opcode_s == OP_STO);
        end else begin
            req_s = 1'b0;
        end
    end

    assign done_s    = req_s & mem_ready;
    assign mem_req   = req_s;
    assign mem_we    = we_s;
    assign mem_addr  = (state_r == ST_FETCH) ? pc_r : (req_s ? opaddr_s : {ADDR_W{1'b0}});
    assign mem_wdata = we_s ? acc_r : {DATA_W{1'b0}};
    assign halt      = (state_r == ST_HALTED);
    assign acc       = acc_r;
    assign pc        = pc_r;
    assign carry     = carry_r;
    assign retired   = retired_r;

    // Next-state selection; memory states hold while the port is waiting.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH:  if (done_s) state_nxt_s = ST_DECODE; else state_nxt_s = ST_FETCH;
            ST_DECODE: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                case (opcode_s)
                    OP_HLT:         state_nxt_s = ST_HALTED;
                    OP_SKZ, OP_JMP: state_nxt_s = ST_FETCH;
                    default: begin
                        if (done_s) state_nxt_s = ST_FETCH; else state_nxt_s = ST_EXEC;
                    end
                endcase
            end
            ST_HALTED: if (go) state_nxt_s = ST_FETCH; else state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_FETCH;
        endcase
    end

    // State, instruction, pc, accumulator, carry and retired-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            ir_r      <= {DATA_W{1'b0}};
            pc_r      <= {ADDR_W{1'b0}};
            acc_r     <= {DATA_W{1'b0}};
            carry_r   <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_FETCH: begin
                    if (done_s) ir_r <= mem_rdata;
                end
                ST_DECODE: pc_r <= pc_r + PC_ONE;
                ST_EXEC: begin
                    case (opcode_s)
                        OP_SKZ: if (acc_r == {DATA_W{1'b0}}) pc_r <= pc_r + PC_ONE;
                        OP_JMP: pc_r <= opaddr_s;
                        OP_ADD: if (done_s) {carry_r, acc_r} <= sum_s;
                        OP_AND: if (done_s) acc_r <= acc_r & mem_rdata;
                        OP_XOR: if (done_s) acc_r <= acc_r ^ mem_rdata;
                        OP_LDA: begin
                            if (done_s) begin
                                acc_r   <= mem_rdata;
                                carry_r <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                    if (state_nxt_s != ST_EXEC && retired_r != CNT_MAX)
                        retired_r <= retired_r + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
